// File: rtl/fft_frame_serializer_if.sv
// fft_frame_serializer_if: bundles the parallel FFT frame bus and the serial output stream.
//   fft_valid, fft_d0..fft_d15 : one-cycle frame strobe and 16 points of {real, imag} Q8.8
//   out_ready                  : downstream accepts the current word
//   out_valid, out_data        : current serial word, captured point unchanged
//   out_mag, out_index         : |real|+|imag| (17 bit unsigned), point number 0..15
//   out_last, busy             : last-word marker, frame held
//   overrun, drop_cnt          : sticky drop flag and saturating drop counter
// Modport slave is the serializer's view; modport master is the surrounding system's view.
interface fft_frame_serializer_if;
  logic        fft_valid;
  logic [31:0] fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7;
  logic [31:0] fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [16:0] out_mag;
  logic [3:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        overrun;
  logic [7:0]  drop_cnt;

  modport slave (
    input  fft_valid,
    input  fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
    input  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    input  out_ready,
    output out_valid, out_data, out_mag, out_index, out_last, busy, overrun, drop_cnt
  );

  modport master (
    output fft_valid,
    output fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
    output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    output out_ready,
    input  out_valid, out_data, out_mag, out_index, out_last, busy, overrun, drop_cnt
  );
endinterface

// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer: captures one 16-point FFT frame from the parallel bus and drains it
// as 16 serial words over a valid/ready handshake, each tagged with its L1 magnitude.
//   clk : system clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : fft_frame_serializer_if.slave (frame input, serial output, status)
// Every output is a register or a buffer mux addressed by the index register, so no input
// reaches an output combinationally.
module fft_frame_serializer (
  input  logic                         clk,
  input  logic                         rst,
  fft_frame_serializer_if.slave        bus
);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  drop_q, drop_d;
  logic [31:0] buf_q [16];
  logic [31:0] fft_d [16];
  logic        capture;
  logic        xfer;
  logic        final_xfer;

  assign fft_d[0]  = bus.fft_d0;
  assign fft_d[1]  = bus.fft_d1;
  assign fft_d[2]  = bus.fft_d2;
  assign fft_d[3]  = bus.fft_d3;
  assign fft_d[4]  = bus.fft_d4;
  assign fft_d[5]  = bus.fft_d5;
  assign fft_d[6]  = bus.fft_d6;
  assign fft_d[7]  = bus.fft_d7;
  assign fft_d[8]  = bus.fft_d8;
  assign fft_d[9]  = bus.fft_d9;
  assign fft_d[10] = bus.fft_d10;
  assign fft_d[11] = bus.fft_d11;
  assign fft_d[12] = bus.fft_d12;
  assign fft_d[13] = bus.fft_d13;
  assign fft_d[14] = bus.fft_d14;
  assign fft_d[15] = bus.fft_d15;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    overrun_d  = overrun_q;
    drop_d     = drop_q;
    capture    = 1'b0;
    xfer       = (state_q == StDrain) && bus.out_ready;
    final_xfer = xfer && (idx_q == 4'd15);
    case (state_q)
      StIdle: begin
        if (bus.fft_valid) begin
          capture = 1'b1;
          idx_d   = 4'd0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (final_xfer) begin
          idx_d = 4'd0;
          // A frame arriving with the final transfer is taken back-to-back, not dropped.
          if (bus.fft_valid) begin
            capture = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + 4'd1;
          end
          if (bus.fft_valid) begin
            overrun_d = 1'b1;
            if (drop_q != 8'hFF) begin
              drop_d = drop_q + 8'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      overrun_q <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  // Buffer is cleared on reset so out_data/out_mag read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= 32'd0;
      end
    end else if (capture) begin
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= fft_d[i];
      end
    end
  end

  logic [31:0] rd_word;
  logic [16:0] re_ext, im_ext;
  logic [16:0] re_abs, im_abs;

  always_comb begin
    rd_word = buf_q[idx_q];
    re_ext  = {rd_word[31], rd_word[31:16]};
    im_ext  = {rd_word[15], rd_word[15:0]};
    // 17-bit magnitudes hold |-32768| exactly, and their sum peaks at 65536.
    re_abs  = re_ext[16] ? (17'd0 - re_ext) : re_ext;
    im_abs  = im_ext[16] ? (17'd0 - im_ext) : im_ext;
  end

  assign bus.out_valid = (state_q == StDrain);
  assign bus.busy      = (state_q == StDrain);
  assign bus.out_data  = rd_word;
  assign bus.out_mag   = re_abs + im_abs;
  assign bus.out_index = idx_q;
  assign bus.out_last  = (state_q == StDrain) && (idx_q == 4'd15);
  assign bus.overrun   = overrun_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_fft_frame_serializer.sv
module tb_fft_frame_serializer;

  logic clk;
  logic rst;

  fft_frame_serializer_if bus ();

  fft_frame_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [16:0] mag;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  beat_t       sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur     [16];
  logic [16:0] cur_mag [16];
  int          ready_mode = 0;
  int          pc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready generator: 0 = always ready, 1 = pattern 1,0,0,1, 2 = never ready.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin
        bus.out_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
        pc++;
      end
      2: bus.out_ready = 1'b0;
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on each transfer and checks stability during stalls.
  logic        stall_prev = 1'b0;
  logic [31:0] held_data;
  logic [16:0] held_mag;
  logic [3:0]  held_idx;
  logic        held_last;

  always @(negedge clk) begin
    if (!rst) begin
      check("busy_eq_valid", {63'd0, bus.busy}, {63'd0, bus.out_valid});
      if (stall_prev && bus.out_valid) begin
        check("stall_data", {32'd0, bus.out_data}, {32'd0, held_data});
        check("stall_mag", {47'd0, bus.out_mag}, {47'd0, held_mag});
        check("stall_index", {60'd0, bus.out_index}, {60'd0, held_idx});
        check("stall_last", {63'd0, bus.out_last}, {63'd0, held_last});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got index %0d data %0h expected no beat",
                   bus.out_index, bus.out_data);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_data", {32'd0, bus.out_data}, {32'd0, e.data});
          check("beat_mag", {47'd0, bus.out_mag}, {47'd0, e.mag});
          check("beat_index", {60'd0, bus.out_index}, {60'd0, e.idx});
          check("beat_last", {63'd0, bus.out_last}, {63'd0, e.last});
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_data  = bus.out_data;
      held_mag   = bus.out_mag;
      held_idx   = bus.out_index;
      held_last  = bus.out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic drive_bus();
    bus.fft_d0  = cur[0];  bus.fft_d1  = cur[1];  bus.fft_d2  = cur[2];  bus.fft_d3  = cur[3];
    bus.fft_d4  = cur[4];  bus.fft_d5  = cur[5];  bus.fft_d6  = cur[6];  bus.fft_d7  = cur[7];
    bus.fft_d8  = cur[8];  bus.fft_d9  = cur[9];  bus.fft_d10 = cur[10]; bus.fft_d11 = cur[11];
    bus.fft_d12 = cur[12]; bus.fft_d13 = cur[13]; bus.fft_d14 = cur[14]; bus.fft_d15 = cur[15];
  endtask

  // Pulses fft_valid for one edge; when push is set the frame is expected on the output.
  task automatic send_frame(input bit push);
    beat_t b;
    drive_bus();
    bus.fft_valid = 1'b1;
    if (push) begin
      for (int k = 0; k < 16; k++) begin
        b.data = cur[k];
        b.mag  = cur_mag[k];
        b.idx  = 4'(k);
        b.last = (k == 15);
        sb.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    bus.fft_valid = 1'b0;
  endtask

  // Frame A: {k, -k}, magnitude 2k.
  task automatic load_a();
    for (int k = 0; k < 16; k++) begin
      cur[k]     = {16'(k), 16'(-k)};
      cur_mag[k] = 17'(2 * k);
    end
  endtask

  // Frame B: {100k, 3}, magnitude 100k + 3.
  task automatic load_b();
    for (int k = 0; k < 16; k++) begin
      cur[k]     = {16'(100 * k), 16'd3};
      cur_mag[k] = 17'(100 * k + 3);
    end
  endtask

  // Frame D: {-2(k+1), k}, magnitude 3k + 2.
  task automatic load_d();
    for (int k = 0; k < 16; k++) begin
      cur[k]     = {16'(-2 * (k + 1)), 16'(k)};
      cur_mag[k] = 17'(3 * k + 2);
    end
  endtask

  // Magnitude corners in words 0..3, {k, 0} elsewhere.
  task automatic load_corners();
    for (int k = 0; k < 16; k++) begin
      cur[k]     = {16'(k), 16'd0};
      cur_mag[k] = 17'(k);
    end
    cur[0] = 32'h8000_8000; cur_mag[0] = 17'd65536;
    cur[1] = 32'h8000_7FFF; cur_mag[1] = 17'd65535;
    cur[2] = 32'hFFFF_0001; cur_mag[2] = 17'd2;
    cur[3] = 32'h0000_0000; cur_mag[3] = 17'd0;
  endtask

  task automatic load_junk();
    for (int k = 0; k < 16; k++) begin
      cur[k]     = 32'h1234_5678;
      cur_mag[k] = 17'd0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 400);
    check(name, {63'd0, bus.busy}, 64'd0);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_index(input string name, input logic [3:0] ix);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.out_valid && bus.out_index == ix) && n < 400);
    check(name, {63'd0, bus.out_valid}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
    check({tag, "_data"}, {32'd0, bus.out_data}, 64'd0);
    check({tag, "_mag"}, {47'd0, bus.out_mag}, 64'd0);
    check({tag, "_index"}, {60'd0, bus.out_index}, 64'd0);
    check({tag, "_last"}, {63'd0, bus.out_last}, 64'd0);
    check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    check({tag, "_overrun"}, {63'd0, bus.overrun}, 64'd0);
    check({tag, "_drop"}, {56'd0, bus.drop_cnt}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.fft_valid = 1'b0;
    bus.out_ready = 1'b1;
    load_junk();
    drive_bus();
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single frame, always ready.
    load_a();
    send_frame(1'b1);
    wait_idle("single_idle");
    check("single_overrun", {63'd0, bus.overrun}, 64'd0);

    // Backpressure 1,0,0,1.
    pc         = 0;
    ready_mode = 1;
    load_b();
    send_frame(1'b1);
    wait_idle("bp_idle");
    ready_mode = 0;

    // Back-to-back: new frame coincides with the word-15 transfer.
    load_a();
    send_frame(1'b1);
    wait_index("b2b_reach15", 4'd15);
    load_d();
    send_frame(1'b1);
    @(negedge clk);
    check("b2b_busy", {63'd0, bus.busy}, 64'd1);
    check("b2b_index", {60'd0, bus.out_index}, 64'd0);
    wait_idle("b2b_idle");
    check("b2b_overrun", {63'd0, bus.overrun}, 64'd0);

    // Reset mid-drain at index 9, between edges.
    load_a();
    send_frame(1'b1);
    wait_index("rst_reach9", 4'd9);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    sb.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Magnitude corners, also confirms a clean restart at index 0.
    load_corners();
    send_frame(1'b1);
    @(negedge clk);
    check("restart_index", {60'd0, bus.out_index}, 64'd0);
    wait_idle("corner_idle");

    // Overrun: drop a frame while index 5 is shown.
    load_b();
    send_frame(1'b1);
    wait_index("ovr_reach5", 4'd5);
    load_junk();
    send_frame(1'b0);
    wait_idle("ovr_idle");
    check("ovr_flag", {63'd0, bus.overrun}, 64'd1);
    check("ovr_cnt1", {56'd0, bus.drop_cnt}, 64'd1);

    // 300 further drops while stalled at index 0.
    ready_mode = 2;
    load_a();
    send_frame(1'b1);
    load_junk();
    repeat (253) send_frame(1'b0);
    check("drop_254", {56'd0, bus.drop_cnt}, 64'd254);
    repeat (47) send_frame(1'b0);
    check("drop_sat", {56'd0, bus.drop_cnt}, 64'd255);
    check("drop_index_held", {60'd0, bus.out_index}, 64'd0);
    ready_mode = 0;
    wait_idle("sat_idle");
    check("sat_overrun", {63'd0, bus.overrun}, 64'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
